// File: rtl/coord_counter.sv
// coord_counter: pixel-stream position tracker.
// Accepts one pixel per enable cycle, registers its (x, y) position with
// line-end, frame-end, sticky restart-error and border flags one cycle later.
// Optional feature macro: COORD_COUNTER_BORDER_EN enables the out_border
// comparators; without it out_border is a constant 0.
module coord_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int MARGIN = 1,
  localparam int X_BITS = (WIDTH  > 2) ? $clog2(WIDTH)  : 1,
  localparam int Y_BITS = (HEIGHT > 2) ? $clog2(HEIGHT) : 1
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              in_frame_start,
  output logic              out_valid,
  output logic [X_BITS-1:0] out_x,
  output logic [Y_BITS-1:0] out_y,
  output logic              out_line_end,
  output logic              out_frame_end,
  output logic              out_error,
  output logic              out_border
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [X_BITS-1:0] LP_X_MAX = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] LP_Y_MAX = Y_BITS'(HEIGHT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [X_BITS-1:0] r_x;
  logic [X_BITS-1:0] w_x_next;
  logic [Y_BITS-1:0] r_y;
  logic [Y_BITS-1:0] w_y_next;
  logic [X_BITS-1:0] w_px_x;
  logic [Y_BITS-1:0] w_px_y;
  logic              w_accept;
  logic              w_restart;
  logic              w_last_x;
  logic              w_last_y;

  logic              r_valid;
  logic [X_BITS-1:0] r_out_x;
  logic [Y_BITS-1:0] r_out_y;
  logic              r_line_end;
  logic              r_frame_end;
  logic              r_error;

  // State and position counters (position of the next expected pixel).
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
    end
  end

  // Decide whether this cycle's pixel is accepted, its position, and the next state.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_px_x       = r_x;
    w_px_y       = r_y;
    w_accept     = 1'b0;
    w_restart    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Only a frame start can open a frame; stray pixels are dropped.
        if (enable && in_frame_start) begin
          w_accept     = 1'b1;
          w_px_x       = '0;
          w_px_y       = '0;
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (enable) begin
          w_accept = 1'b1;
          if (in_frame_start) begin
            // Early restart: the new frame begins at (0,0) and the error is latched.
            w_restart = 1'b1;
            w_px_x    = '0;
            w_px_y    = '0;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_last_x = (w_px_x == LP_X_MAX);
    w_last_y = (w_px_y == LP_Y_MAX);

    // Explicit end-of-line / end-of-frame handling so odd sizes never rely on wrap.
    if (w_accept) begin
      if (w_last_x) begin
        w_x_next = '0;
        if (w_last_y) begin
          w_y_next     = '0;
          w_state_next = S_IDLE;
        end else begin
          w_y_next = w_px_y + Y_BITS'(1);
        end
      end else begin
        w_x_next = w_px_x + X_BITS'(1);
        w_y_next = w_px_y;
      end
    end
  end

  // Registered outputs describing the pixel accepted in the previous cycle.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_valid     <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid     <= w_accept;
      r_line_end  <= w_accept & w_last_x;
      r_frame_end <= w_accept & w_last_x & w_last_y;
      if (w_accept) begin
        r_out_x <= w_px_x;
        r_out_y <= w_px_y;
      end
      if (w_restart) begin
        r_error <= 1'b1;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_x         = r_out_x;
  assign out_y         = r_out_y;
  assign out_line_end  = r_line_end;
  assign out_frame_end = r_frame_end;
  assign out_error     = r_error;

`ifdef COORD_COUNTER_BORDER_EN
  logic w_border_hit;
  logic r_border;

  generate
    if (MARGIN == 0) begin : g_no_margin
      assign w_border_hit = 1'b0;
    end else begin : g_margin
      localparam logic [X_BITS-1:0] LP_X_LO = X_BITS'(MARGIN);
      localparam logic [X_BITS-1:0] LP_X_HI = X_BITS'(WIDTH - MARGIN);
      localparam logic [Y_BITS-1:0] LP_Y_LO = Y_BITS'(MARGIN);
      localparam logic [Y_BITS-1:0] LP_Y_HI = Y_BITS'(HEIGHT - MARGIN);
      assign w_border_hit = (w_px_x < LP_X_LO) | (w_px_x >= LP_X_HI) |
                            (w_px_y < LP_Y_LO) | (w_px_y >= LP_Y_HI);
    end
  endgenerate

  // Border flag registered alongside the coordinates; zero when no pixel is valid.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_border <= 1'b0;
    end else begin
      r_border <= w_accept & w_border_hit;
    end
  end

  assign out_border = r_border;
`else
  // Border detection not built; MARGIN is never negative, so this is constant 0.
  assign out_border = (MARGIN < 0);
`endif

endmodule

// File: tb/tb_coord_counter.sv
// Directed testbench for coord_counter on a 4x3 frame with MARGIN=1.
// Covers reset values, continuous and gapped frames, frame start right after
// frame end, early restart with sticky error, stray pixels in IDLE and an
// asynchronous mid-frame reset.
module tb_coord_counter;

  logic       clock;
  logic       n_rst;
  logic       enable;
  logic       in_frame_start;
  logic       out_valid;
  logic [1:0] out_x;
  logic [1:0] out_y;
  logic       out_line_end;
  logic       out_frame_end;
  logic       out_error;
  logic       out_border;

  int n_checks = 0;
  int n_errors = 0;

  // Border map of a 4x3 frame with MARGIN=1, bit index = y*4 + x.
  // Only (1,1) and (2,1) are interior.
  logic [11:0] border_map;

  coord_counter #(
    .WIDTH (4),
    .HEIGHT(3),
    .MARGIN(1)
  ) dut (
    .clock         (clock),
    .n_rst         (n_rst),
    .enable        (enable),
    .in_frame_start(in_frame_start),
    .out_valid     (out_valid),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_line_end  (out_line_end),
    .out_frame_end (out_frame_end),
    .out_error     (out_error),
    .out_border    (out_border)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle and land 1 ns after the sampling edge.
  task automatic drive(input logic en, input logic fs);
    enable         = en;
    in_frame_start = fs;
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_border(input int x, input int y);
`ifdef COORD_COUNTER_BORDER_EN
    return border_map[y*4 + x];
`else
    return 1'b0;
`endif
  endfunction

  // Check one valid output pixel.
  task automatic check_px(input string tag, input int x, input int y,
                          input logic le, input logic fe, input logic err);
    $display("%s: pixel x=%0d y=%0d line_end=%0b frame_end=%0b err=%0b border=%0b",
             tag, out_x, out_y, out_line_end, out_frame_end, out_error, out_border);
    check({tag, " valid"},     int'(out_valid),     1);
    check({tag, " x"},         int'(out_x),         x);
    check({tag, " y"},         int'(out_y),         y);
    check({tag, " line_end"},  int'(out_line_end),  int'(le));
    check({tag, " frame_end"}, int'(out_frame_end), int'(fe));
    check({tag, " error"},     int'(out_error),     int'(err));
    check({tag, " border"},    int'(out_border),    int'(exp_border(x, y)));
  endtask

  // Check an idle output cycle; coordinates are compared only when they must hold.
  task automatic check_gap(input string tag, input bit chk_xy, input int x, input int y,
                           input logic err);
    $display("%s: gap valid=%0b x=%0d y=%0d err=%0b", tag, out_valid, out_x, out_y, out_error);
    check({tag, " valid"},     int'(out_valid),     0);
    check({tag, " line_end"},  int'(out_line_end),  0);
    check({tag, " frame_end"}, int'(out_frame_end), 0);
    check({tag, " border"},    int'(out_border),    0);
    check({tag, " error"},     int'(out_error),     int'(err));
    if (chk_xy) begin
      check({tag, " x hold"}, int'(out_x), x);
      check({tag, " y hold"}, int'(out_y), y);
    end
  endtask

  initial begin
    border_map     = 12'b1111_1001_1111;
    n_rst          = 1'b0;
    enable         = 1'b0;
    in_frame_start = 1'b0;

    // Reset values.
    #2;
    check_gap("reset", 1'b1, 0, 0, 1'b0);
    #10;
    n_rst = 1'b1;

    // Pixels without a frame start are ignored after reset.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0);
      check_gap("no_fs", 1'b1, 0, 0, 1'b0);
    end

    // Continuous 4x3 frame.
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, k == 0);
      check_px("cont", k % 4, k / 4, (k % 4) == 3, k == 11, 1'b0);
    end

    // Gapped frame; its frame start immediately follows the previous frame end.
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, k == 0);
      check_px("gap_px", k % 4, k / 4, (k % 4) == 3, k == 11, 1'b0);
      drive(1'b0, 1'b0);
      check_gap("gap_hold", 1'b1, k % 4, k / 4, 1'b0);
    end

    // After frame end no wrap: pixels without frame start are dropped.
    drive(1'b1, 1'b0);
    check_gap("no_wrap", 1'b0, 0, 0, 1'b0);

    // Early restart at (1,1): next output is (0,0) with sticky error.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 0);
      check_px("pre_restart", k % 4, k / 4, (k % 4) == 3, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1);
    check_px("restart", 0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 12; k++) begin
      drive(1'b1, 1'b0);
      check_px("post_restart", k % 4, k / 4, (k % 4) == 3, k == 11, 1'b1);
    end
    drive(1'b0, 1'b0);
    check_gap("err_sticky", 1'b1, 3, 2, 1'b1);

    // Asynchronous reset while at (2,1).
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, k == 0);
      check_px("pre_reset", k % 4, k / 4, (k % 4) == 3, 1'b0, 1'b1);
    end
    enable         = 1'b0;
    in_frame_start = 1'b0;
    #3;
    n_rst = 1'b0;
    #1;
    check_gap("async_rst", 1'b1, 0, 0, 1'b0);
    #3;
    n_rst = 1'b1;

    drive(1'b1, 1'b0);
    check_gap("rst_no_fs", 1'b1, 0, 0, 1'b0);
    drive(1'b1, 1'b1);
    check_px("rst_fs", 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    check_px("rst_next", 1, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
